// File: rtl/sprite_attr_fetch.sv
// sprite_attr_fetch: per-scanline walk of the sprite attribute RAM.
// Each line start scans every sprite in index order (two RAM words per
// sprite). Sprites that cover the current line are handed to the line
// renderer over a valid/ready port, up to MAX_HITS per line. Hits past
// that limit are dropped and flagged on a sticky overflow bit.
module sprite_attr_fetch #(
  parameter int NUM_SPRITES = 128,
  parameter int MAX_HITS    = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          sprite_enable_i,
  input  logic                          line_start_i,
  input  logic [9:0]                    line_i,
  output logic                          rd_en_o,
  output logic [$clog2(NUM_SPRITES):0]  rd_addr_o,
  input  logic [31:0]                   rd_data_i,
  output logic                          spr_valid_o,
  input  logic                          spr_ready_i,
  output logic [$clog2(NUM_SPRITES)-1:0] spr_idx_o,
  output logic [11:0]                   spr_addr_o,
  output logic                          spr_mode_o,
  output logic [9:0]                    spr_x_o,
  output logic [5:0]                    spr_row_o,
  output logic [1:0]                    spr_z_o,
  output logic                          spr_hflip_o,
  output logic [1:0]                    spr_width_o,
  output logic [3:0]                    spr_palofs_o,
  output logic [3:0]                    spr_collmask_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          overflow_o
);

  localparam int IW = $clog2(NUM_SPRITES);
  localparam int HW = $clog2(MAX_HITS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD0, S_RD1, S_EVAL, S_PRESENT, S_NEXT
  } state_t;

  // Descriptor handed to the renderer; held stable while PRESENT stalls.
  typedef struct packed {
    logic [IW-1:0] idx;
    logic [11:0]   addr;
    logic          mode;
    logic [9:0]    x;
    logic [5:0]    row;
    logic [1:0]    z;
    logic          hflip;
    logic [1:0]    width;
    logic [3:0]    palofs;
    logic [3:0]    collmask;
  } desc_t;

  state_t        state_q, state_d;
  logic [9:0]    line_q;
  logic [IW-1:0] idx_q;
  logic [HW-1:0] hits_q;
  logic          ovf_q;
  desc_t         desc_q, desc_d;

  // Word-0 fields kept from the RD1 cycle until the sprite is evaluated.
  logic [11:0]   w0_addr_q;
  logic          w0_mode_q;
  logic [9:0]    w0_x_q;

  logic          start;
  logic          last;
  logic          room;
  logic [9:0]    dy;
  logic [6:0]    rows;
  logic [6:0]    row_flip;
  logic          hit;
  logic          unused_bits;

  // Word-0 bits 14:12 and the top of X's byte carry no meaning here.
  assign unused_bits = ^rd_data_i[14:12];

  // A line start with the block enabled (re)starts the scan from any state.
  assign start = line_start_i & sprite_enable_i;
  assign last  = (idx_q == IW'(NUM_SPRITES - 1));
  assign room  = (hits_q < HW'(MAX_HITS));

  // Word-1 decode in EVAL: the RAM presents w1 this cycle. dy wraps mod
  // 1024 so sprites parked near Y=1023 still cover the first lines.
  always_comb begin
    rows     = 7'd8 << rd_data_i[31:30];
    dy       = line_q - rd_data_i[9:0];
    hit      = (rd_data_i[19:18] != 2'd0) && (dy < {3'd0, rows});
    row_flip = rows - 7'd1 - dy[6:0];

    desc_d.idx      = idx_q;
    desc_d.addr     = w0_addr_q;
    desc_d.mode     = w0_mode_q;
    desc_d.x        = w0_x_q;
    desc_d.row      = rd_data_i[17] ? row_flip[5:0] : dy[5:0];
    desc_d.z        = rd_data_i[19:18];
    desc_d.hflip    = rd_data_i[16];
    desc_d.width    = rd_data_i[29:28];
    desc_d.palofs   = rd_data_i[27:24];
    desc_d.collmask = rd_data_i[23:20];
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state and RAM read port. A line start while busy aborts the scan.
  always_comb begin
    state_d   = state_q;
    rd_en_o   = 1'b0;
    rd_addr_o = '0;
    case (state_q)
      S_IDLE:    state_d = S_IDLE;
      S_RD0: begin
        rd_en_o   = 1'b1;
        rd_addr_o = {idx_q, 1'b0};
        state_d   = S_RD1;
      end
      S_RD1: begin
        rd_en_o   = 1'b1;
        rd_addr_o = {idx_q, 1'b1};
        state_d   = S_EVAL;
      end
      S_EVAL:    state_d = (hit && room) ? S_PRESENT : S_NEXT;
      S_PRESENT: if (spr_ready_i) state_d = S_NEXT;
      S_NEXT:    state_d = last ? S_IDLE : S_RD0;
      default:   state_d = S_IDLE;
    endcase
    if (line_start_i) state_d = sprite_enable_i ? S_RD0 : S_IDLE;
  end

  // Scan counters, per-line overflow flag and word-0 capture.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      line_q    <= '0;
      idx_q     <= '0;
      hits_q    <= '0;
      ovf_q     <= 1'b0;
      w0_addr_q <= '0;
      w0_mode_q <= 1'b0;
      w0_x_q    <= '0;
    end else if (start) begin
      line_q <= line_i;
      idx_q  <= '0;
      hits_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      case (state_q)
        S_RD1: begin
          w0_addr_q <= rd_data_i[11:0];
          w0_mode_q <= rd_data_i[15];
          w0_x_q    <= rd_data_i[25:16];
        end
        S_EVAL:    if (hit && !room) ovf_q <= 1'b1;
        S_PRESENT: if (spr_ready_i) hits_q <= hits_q + HW'(1);
        S_NEXT:    if (!last) idx_q <= idx_q + IW'(1);
        default: ;
      endcase
    end
  end

  // Descriptor register: loaded only when a hit still fits in the line budget.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                                       desc_q <= '0;
    else if (!line_start_i && state_q == S_EVAL && hit && room) desc_q <= desc_d;
  end

  assign spr_valid_o    = (state_q == S_PRESENT);
  assign busy_o         = (state_q != S_IDLE);
  assign done_o         = (state_q == S_NEXT) && last && !line_start_i;
  assign overflow_o     = ovf_q;
  assign spr_idx_o      = desc_q.idx;
  assign spr_addr_o     = desc_q.addr;
  assign spr_mode_o     = desc_q.mode;
  assign spr_x_o        = desc_q.x;
  assign spr_row_o      = desc_q.row;
  assign spr_z_o        = desc_q.z;
  assign spr_hflip_o    = desc_q.hflip;
  assign spr_width_o    = desc_q.width;
  assign spr_palofs_o   = desc_q.palofs;
  assign spr_collmask_o = desc_q.collmask;

endmodule

// File: tb/tb_sprite_attr_fetch.sv
// Bench for sprite_attr_fetch: RAM model, line-level reference model feeding
// an expected-descriptor queue, and an independent handshake monitor.
module tb_sprite_attr_fetch;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        sprite_enable_i = 1'b1;
  logic        line_start_i = 1'b0;
  logic [9:0]  line_i = '0;
  logic        rd_en_o;
  logic [7:0]  rd_addr_o;
  logic [31:0] rd_data_i = '0;
  logic        spr_valid_o;
  logic        spr_ready_i = 1'b1;
  logic [6:0]  spr_idx_o;
  logic [11:0] spr_addr_o;
  logic        spr_mode_o;
  logic [9:0]  spr_x_o;
  logic [5:0]  spr_row_o;
  logic [1:0]  spr_z_o;
  logic        spr_hflip_o;
  logic [1:0]  spr_width_o;
  logic [3:0]  spr_palofs_o;
  logic [3:0]  spr_collmask_o;
  logic        busy_o, done_o, overflow_o;

  sprite_attr_fetch dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .sprite_enable_i(sprite_enable_i),
    .line_start_i(line_start_i), .line_i(line_i),
    .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
    .spr_valid_o(spr_valid_o), .spr_ready_i(spr_ready_i),
    .spr_idx_o(spr_idx_o), .spr_addr_o(spr_addr_o), .spr_mode_o(spr_mode_o),
    .spr_x_o(spr_x_o), .spr_row_o(spr_row_o), .spr_z_o(spr_z_o),
    .spr_hflip_o(spr_hflip_o), .spr_width_o(spr_width_o),
    .spr_palofs_o(spr_palofs_o), .spr_collmask_o(spr_collmask_o),
    .busy_o(busy_o), .done_o(done_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [6:0]  idx;
    logic [11:0] addr;
    logic        mode;
    logic [9:0]  x;
    logic [5:0]  row;
    logic [1:0]  z;
    logic        hflip;
    logic [1:0]  width;
    logic [3:0]  palofs;
    logic [3:0]  coll;
  } desc_t;

  logic [31:0] mem [256];
  desc_t       exp_q [$];
  desc_t       last_act;
  desc_t       prev;
  bit          hold = 0;
  int          n_chk = 0, n_pass = 0, n_desc = 0;
  int          rdy_mode = 0;  // 0: ready high, 1: random ready, 2: driven by hand

  // Attribute RAM read port, one-cycle latency.
  always @(posedge clk_i) if (rd_en_o) rd_data_i <= mem[rd_addr_o];

  // Renderer back-pressure.
  always @(posedge clk_i) begin
    #1;
    if (rdy_mode == 0)      spr_ready_i = 1'b1;
    else if (rdy_mode == 1) spr_ready_i = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Monitor: every accepted descriptor must match the queue head; a stalled
  // descriptor must not change until it is accepted.
  always @(negedge clk_i) begin
    desc_t act;
    desc_t e;
    act = {spr_idx_o, spr_addr_o, spr_mode_o, spr_x_o, spr_row_o, spr_z_o,
           spr_hflip_o, spr_width_o, spr_palofs_o, spr_collmask_o};
    if (rst_n_i && spr_valid_o) begin
      if (hold) chk("stall_stable", 64'(act), 64'(prev));
      if (spr_ready_i) begin
        chk("desc_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("desc", 64'(act), 64'(e));
          n_desc++;
          last_act = act;
        end
      end
    end
    hold = rst_n_i && spr_valid_o && !spr_ready_i;
    prev = act;
  end

  // Reference model: what the renderer should receive for one line.
  task automatic model_line(input int line, output int nh, output bit ov);
    desc_t d;
    nh = 0;
    ov = 0;
    for (int s = 0; s < 128; s++) begin
      int unsigned w0, w1;
      int y, rows, dy, z;
      w0   = mem[2*s];
      w1   = mem[2*s+1];
      y    = int'(w1 % 1024);
      rows = 8 << (w1 >> 30);
      dy   = (line - y + 1024) % 1024;
      z    = int'((w1 >> 18) % 4);
      if (z != 0 && dy < rows) begin
        if (nh < 64) begin
          d.idx    = 7'(s);
          d.addr   = 12'(w0 % 4096);
          d.mode   = 1'((w0 >> 15) % 2);
          d.x      = 10'((w0 >> 16) % 1024);
          d.row    = ((w1 >> 17) % 2 == 1) ? 6'(rows - 1 - dy) : 6'(dy);
          d.z      = 2'(z);
          d.hflip  = 1'((w1 >> 16) % 2);
          d.width  = 2'((w1 >> 28) % 4);
          d.palofs = 4'((w1 >> 24) % 16);
          d.coll   = 4'((w1 >> 20) % 16);
          exp_q.push_back(d);
          nh++;
        end else begin
          ov = 1;
        end
      end
    end
  endtask

  function automatic logic [31:0] mk_w1(input int y, input int h, input int z, input int vflip);
    logic [31:0] r;
    r = $urandom & 32'h3FF1_FC00;
    return r | (32'(h) << 30) | (32'(z) << 18) | (32'(vflip) << 17) | 32'(y);
  endfunction

  // Random junk everywhere, but no sprite visible (Z=0).
  task automatic clear_mem();
    for (int i = 0; i < 256; i++)
      mem[i] = (i % 2 == 1) ? ($urandom & ~32'h000C_0000) : $urandom;
  endtask

  task automatic start_line(input int line, output int nh, output bit ov);
    exp_q.delete();
    model_line(line, nh, ov);
    n_desc = 0;
    @(posedge clk_i); #1;
    line_i = 10'(line);
    line_start_i = 1'b1;
    @(posedge clk_i); #1;
    line_start_i = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int nh, input bit ov, input bit timing);
    int cyc = 1;
    while (!done_o && cyc < 5000) begin @(posedge clk_i); #1; cyc++; end
    chk({nm, "_done"}, 64'(done_o), 64'd1);
    if (timing) chk({nm, "_cycles"}, 64'(cyc), 64'(512 + nh));
    chk({nm, "_overflow"}, 64'(overflow_o), 64'(ov));
    @(posedge clk_i); #1;
    chk({nm, "_idle"}, 64'({busy_o, done_o}), 64'd0);
    @(negedge clk_i);
    chk({nm, "_leftover"}, 64'(exp_q.size()), 64'd0);
    chk({nm, "_count"}, 64'(n_desc), 64'(nh));
  endtask

  task automatic wait_valid(input string nm);
    int cyc = 0;
    while (!spr_valid_o && cyc < 2000) begin @(posedge clk_i); #1; cyc++; end
    chk({nm, "_valid"}, 64'(spr_valid_o), 64'd1);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({rd_en_o, rd_addr_o, spr_valid_o, spr_idx_o, spr_addr_o, spr_mode_o,
                spr_x_o, spr_row_o, spr_z_o, spr_hflip_o, spr_width_o, spr_palofs_o,
                spr_collmask_o, busy_o, done_o, overflow_o});
  endfunction

  initial begin
    int  nh;
    bit  ov;
    int  ln;

    clear_mem();
    repeat (3) @(posedge clk_i);
    #1 chk("reset_outputs", all_outs(), 64'd0);
    @(negedge clk_i) rst_n_i = 1'b1;

    // 1: single 16-row sprite, line inside it
    mem[11] = mk_w1(100, 1, 3, 0);
    start_line(107, nh, ov);
    wait_done("t1", nh, ov, 1);
    chk("t1_idx", 64'(last_act.idx), 64'd5);
    chk("t1_row", 64'(last_act.row), 64'd7);

    // 2: vertical flip, then line just past the bottom
    mem[11] = mk_w1(100, 1, 3, 1);
    start_line(100, nh, ov);
    wait_done("t2a", nh, ov, 1);
    chk("t2a_row", 64'(last_act.row), 64'd15);
    start_line(116, nh, ov);
    wait_done("t2b", nh, ov, 1);
    chk("t2b_none", 64'(n_desc), 64'd0);

    // 3: Y wraps past 1023; enable drops mid-scan on the miss line
    clear_mem();
    mem[1] = mk_w1(1020, 0, 1, 0);
    start_line(3, nh, ov);
    wait_done("t3a", nh, ov, 1);
    chk("t3a_row", 64'(last_act.row), 64'd7);
    chk("t3a_idx", 64'(last_act.idx), 64'd0);
    start_line(4, nh, ov);
    repeat (20) @(posedge clk_i);
    #1 sprite_enable_i = 1'b0;
    wait_done("t3b", nh, ov, 0);
    chk("t3b_none", 64'(n_desc), 64'd0);

    // enable low: line start ignored
    @(posedge clk_i); #1 line_start_i = 1'b1;
    @(posedge clk_i); #1 line_start_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 chk("disabled_idle", 64'({busy_o, rd_en_o}), 64'd0);
    sprite_enable_i = 1'b1;

    // 4: 70 hits on line 0, only 64 forwarded
    clear_mem();
    for (int s = 0; s < 70; s++) mem[2*s+1] = mk_w1(0, 0, 1, 0);
    start_line(0, nh, ov);
    wait_done("t4", nh, ov, 1);
    chk("t4_last_idx", 64'(last_act.idx), 64'd63);
    chk("t4_overflow", 64'(overflow_o), 64'd1);

    // 5: renderer stalls 10 cycles, scan resumes with the next sprite
    clear_mem();
    mem[11] = mk_w1(100, 1, 3, 0);
    mem[13] = mk_w1(104, 0, 2, 1);
    rdy_mode = 2;
    spr_ready_i = 1'b0;
    start_line(107, nh, ov);
    wait_valid("t5");
    repeat (10) @(posedge clk_i);
    #1 chk("t5_held", 64'(spr_valid_o), 64'd1);
    chk("t5_idx", 64'(spr_idx_o), 64'd5);
    rdy_mode = 0;
    spr_ready_i = 1'b1;
    wait_done("t5", nh, ov, 0);
    chk("t5_resume_idx", 64'(last_act.idx), 64'd6);
    chk("t5_resume_row", 64'(last_act.row), 64'd4);

    // 6a: line start during PRESENT aborts and restarts on the new line
    mem[19] = mk_w1(200, 0, 2, 0);
    rdy_mode = 2;
    spr_ready_i = 1'b0;
    start_line(107, nh, ov);
    wait_valid("t6a");
    start_line(203, nh, ov);
    chk("t6a_dropped", 64'({spr_valid_o, busy_o}), 64'b01);
    rdy_mode = 0;
    spr_ready_i = 1'b1;
    wait_done("t6a", nh, ov, 1);
    chk("t6a_idx", 64'(last_act.idx), 64'd9);
    chk("t6a_row", 64'(last_act.row), 64'd3);

    // 6b: reset mid-scan clears every output at once
    rdy_mode = 2;
    spr_ready_i = 1'b0;
    start_line(107, nh, ov);
    wait_valid("t6b");
    #2 rst_n_i = 1'b0;
    #1 chk("t6b_reset_outputs", all_outs(), 64'd0);
    exp_q.delete();
    @(negedge clk_i) rst_n_i = 1'b1;
    rdy_mode = 0;
    spr_ready_i = 1'b1;
    start_line(107, nh, ov);
    wait_done("t6b_after", nh, ov, 1);

    // random attribute tables, sparse and dense, random back-pressure
    rdy_mode = 1;
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      if (t % 2 == 1) begin
        for (int s = 0; s < 128; s++)
          mem[2*s+1] = (mem[2*s+1] & ~32'h3FF) | 32'($urandom_range(0, 40));
        ln = $urandom_range(0, 40);
      end else begin
        ln = $urandom_range(0, 1023);
      end
      start_line(ln, nh, ov);
      wait_done("rand", nh, ov, 0);
    end
    rdy_mode = 0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    for (int s = 0; s < 128; s++)
      mem[2*s+1] = (mem[2*s+1] & ~32'h3FF) | 32'($urandom_range(0, 20));
    start_line($urandom_range(0, 20), nh, ov);
    wait_done("rand_dense", nh, ov, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
